// File: rtl/banked_row_pkg.sv
// Shared types and default sizing for the banked row controller.
// Contents: default parameter values, derived address widths (ROW_W, COL_W),
// the controller FSM state enum, slot/row storage typedefs at the default
// sizing, and a helper that returns a safe index width.
package banked_row_pkg;

  localparam int unsigned DefNumCh       = 2;
  localparam int unsigned DefRowDepth    = 64;
  localparam int unsigned DefSlotWidth   = 32;
  localparam int unsigned DefSlotsPerRow = 2;
  localparam int unsigned DefColsPerSlot = 32;
  localparam int unsigned DefMemLatency  = 2;

  localparam int unsigned ROW_W = $clog2(DefRowDepth);
  localparam int unsigned COL_W = $clog2(DefSlotsPerRow * DefColsPerSlot);

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StMod,
    StRsp
  } state_e;

  typedef struct packed {
    logic                    valid;
    logic [DefSlotWidth-1:0] data;
  } slot_t;

  typedef slot_t [DefSlotsPerRow-1:0] row_t;

  // Width of an index into n items; never zero so a 1-entry range still works.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   req          : per-channel request vector
//   advance      : move the pointer past the current grant
//   grant        : one-hot grant, lowest requesting index at or after the pointer
module rr_arbiter
  import banked_row_pkg::*;
#(
  parameter int unsigned NUM_CH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

  localparam int unsigned PtrW = idx_width(NUM_CH);

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_d;
  logic [PtrW:0]   cand;
  logic            found;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Candidate index (ptr + i) mod NUM_CH, one bit wider to hold the wrap.
      cand = {1'b0, ptr_q} + (PtrW + 1)'(i);
      if (cand >= (PtrW + 1)'(NUM_CH)) begin
        cand = cand - (PtrW + 1)'(NUM_CH);
      end
      if (!found && req[cand[PtrW-1:0]]) begin
        found                 = 1'b1;
        grant[cand[PtrW-1:0]] = 1'b1;
        ptr_d = (cand == (PtrW + 1)'(NUM_CH - 1)) ? '0 : cand[PtrW-1:0] + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/banked_row_ctrl.sv
// Multi-channel controller for one row-organised storage bank.
// Each row holds SLOTS_PER_ROW slots of SLOT_WIDTH bits with a valid bit per
// slot; the slot is req_col / COLS_PER_SLOT. One request is in flight at a
// time; channels are served round-robin.
// Ports:
//   clock, reset          : clock and asynchronous active-high reset
//   req_valid/req_write   : per-channel strobe (held until req_ready) and write flag
//   req_row/req_col       : packed per-channel row and column addresses
//   req_wdata             : packed per-channel write data
//   req_ready             : one-hot grant pulse
//   rsp_valid             : one-cycle completion pulse to the granted channel
//   rsp_data              : read data, or the written value for writes
//   busy                  : FSM not idle
//   dirty_rows            : per-row flag, set by any write
// Optional feature: define ROW_HIT_BYPASS_EN to skip the bank read when the
// granted row is the same as the last accessed row.
module banked_row_ctrl
  import banked_row_pkg::*;
#(
  parameter int unsigned NUM_CH        = DefNumCh,
  parameter int unsigned ROW_DEPTH     = DefRowDepth,
  parameter int unsigned SLOT_WIDTH    = DefSlotWidth,
  parameter int unsigned SLOTS_PER_ROW = DefSlotsPerRow,
  parameter int unsigned COLS_PER_SLOT = DefColsPerSlot,
  parameter int unsigned MEM_LATENCY   = DefMemLatency
) (
  input  logic                                                  clock,
  input  logic                                                  reset,
  input  logic [NUM_CH-1:0]                                     req_valid,
  input  logic [NUM_CH-1:0]                                     req_write,
  input  logic [NUM_CH*$clog2(ROW_DEPTH)-1:0]                   req_row,
  input  logic [NUM_CH*$clog2(SLOTS_PER_ROW*COLS_PER_SLOT)-1:0] req_col,
  input  logic [NUM_CH*SLOT_WIDTH-1:0]                          req_wdata,
  output logic [NUM_CH-1:0]                                     req_ready,
  output logic [NUM_CH-1:0]                                     rsp_valid,
  output logic [SLOT_WIDTH-1:0]                                 rsp_data,
  output logic                                                  busy,
  output logic [ROW_DEPTH-1:0]                                  dirty_rows
);

  localparam int unsigned RowW    = $clog2(ROW_DEPTH);
  localparam int unsigned ColW    = $clog2(SLOTS_PER_ROW * COLS_PER_SLOT);
  localparam int unsigned SlotW   = idx_width(SLOTS_PER_ROW);
  localparam int unsigned CntW    = idx_width(MEM_LATENCY);
  localparam int unsigned RowBits = SLOTS_PER_ROW * SLOT_WIDTH;

  state_e                   state_q;
  logic [NUM_CH-1:0]        grant;
  logic [NUM_CH-1:0]        grant_q;
  logic [NUM_CH-1:0]        req_ready_q;
  logic [NUM_CH-1:0]        rsp_valid_q;
  logic [SLOT_WIDTH-1:0]    rsp_data_q;
  logic [RowW-1:0]          row_q;
  logic [SlotW-1:0]         slot_q;
  logic                     wr_q;
  logic [SLOT_WIDTH-1:0]    wdata_q;
  logic [RowBits-1:0]       row_data_q;
  logic [CntW-1:0]          cnt_q;
  logic [SLOTS_PER_ROW-1:0] valid_q [ROW_DEPTH];
  logic [ROW_DEPTH-1:0]     dirty_q;
  logic [RowBits-1:0]       mem [ROW_DEPTH];

  logic [RowW-1:0]       sel_row;
  logic [ColW-1:0]       sel_col;
  logic                  sel_write;
  logic [SLOT_WIDTH-1:0] sel_wdata;
  logic [SlotW-1:0]      sel_slot;
  logic                  advance;
  logic                  hit;
  logic                  mem_we;
  int unsigned           slot_lsb;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (req_valid),
    .advance(advance),
    .grant  (grant)
  );

  assign advance  = (state_q == StIdle) && (|req_valid);
  assign sel_slot = SlotW'(32'(sel_col) / COLS_PER_SLOT);
  assign slot_lsb = 32'(slot_q) * SLOT_WIDTH;
  assign mem_we   = (state_q == StMod) && wr_q;

  // Mux the granted channel's request fields.
  always_comb begin
    sel_row   = '0;
    sel_col   = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        sel_row   = req_row[c*RowW +: RowW];
        sel_col   = req_col[c*ColW +: ColW];
        sel_write = req_write[c];
        sel_wdata = req_wdata[c*SLOT_WIDTH +: SLOT_WIDTH];
      end
    end
  end

`ifdef ROW_HIT_BYPASS_EN
  // row_data_q/row_q already hold the last accessed row (writes are merged in
  // the modify state), so the buffer only needs a flag saying that content is
  // live. The valid bits come straight from valid_q, which is always current.
  logic buf_vld_q;
  assign hit = buf_vld_q && (sel_row == row_q);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      row_q       <= '0;
      slot_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      row_data_q  <= '0;
      cnt_q       <= '0;
      dirty_q     <= '0;
      for (int r = 0; r < ROW_DEPTH; r++) begin
        valid_q[r] <= '0;
      end
`ifdef ROW_HIT_BYPASS_EN
      buf_vld_q <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        StIdle: begin
          if (advance) begin
            req_ready_q <= grant;
            grant_q     <= grant;
            row_q       <= sel_row;
            slot_q      <= sel_slot;
            wr_q        <= sel_write;
            wdata_q     <= sel_wdata;
            cnt_q       <= '0;
            state_q     <= hit ? StMod : StRd;
          end
        end
        StRd: begin
          // Captured every cycle; the last capture is the one the modify state consumes.
          row_data_q <= mem[row_q];
          if (cnt_q == CntW'(MEM_LATENCY - 1)) begin
            state_q <= StMod;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StMod: begin
          if (wr_q) begin
            rsp_data_q                          <= wdata_q;
            row_data_q[slot_lsb +: SLOT_WIDTH] <= wdata_q;
            valid_q[row_q][slot_q]              <= 1'b1;
            dirty_q[row_q]                      <= 1'b1;
          end else begin
            rsp_data_q <= valid_q[row_q][slot_q] ? row_data_q[slot_lsb +: SLOT_WIDTH] : '0;
          end
`ifdef ROW_HIT_BYPASS_EN
          buf_vld_q <= 1'b1;
`endif
          state_q <= StRsp;
        end
        StRsp: begin
          rsp_valid_q <= grant_q;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bank storage is deliberately not reset; cleared valid bits hide stale data.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[row_q][slot_lsb +: SLOT_WIDTH] <= wdata_q;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q != StIdle);
  assign dirty_rows = dirty_q;

endmodule

// File: tb/tb_banked_row_ctrl.sv
// Self-checking bench for banked_row_ctrl at the default sizing.
module tb_banked_row_ctrl;
  import banked_row_pkg::*;

  localparam int NC  = DefNumCh;
  localparam int RW  = ROW_W;
  localparam int CW  = COL_W;
  localparam int SW  = DefSlotWidth;
  localparam int LAT = DefMemLatency;
  localparam int RD  = DefRowDepth;
  localparam int CPS = DefColsPerSlot;
`ifdef ROW_HIT_BYPASS_EN
  localparam int HitLat = 2;
`else
  localparam int HitLat = LAT + 2;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [NC-1:0]  req_valid = '0;
  logic [NC-1:0]  req_write = '0;
  logic [NC*RW-1:0] req_row = '0;
  logic [NC*CW-1:0] req_col = '0;
  logic [NC*SW-1:0] req_wdata = '0;
  logic [NC-1:0]  req_ready;
  logic [NC-1:0]  rsp_valid;
  logic [SW-1:0]  rsp_data;
  logic           busy;
  logic [RD-1:0]  dirty_rows;

  always #5 clock = ~clock;

  banked_row_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_row   (req_row),
    .req_col   (req_col),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .dirty_rows(dirty_rows)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural model: per-row slot contents, dirty flags, rr pointer, last row.
  row_t          m_mem [RD];
  logic [RD-1:0] m_dirty;
  int            m_ptr;
  int            m_last_row;
  bit            m_last_vld;

  int            exp_at = -1;
  int            exp_ch = 0;
  logic [SW-1:0] exp_data = '0;

  logic [SW-1:0] rsp_log[$];
  int            rsp_cyc_log[$];
  int            grant_log[$];
  int            gcyc_log[$];

  logic          op_wr [NC];
  int            op_row[NC];
  int            op_col[NC];
  logic [SW-1:0] op_wd [NC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < RD; r++) m_mem[r] = '0;
    m_dirty    = '0;
    m_ptr      = 0;
    m_last_row = 0;
    m_last_vld = 1'b0;
  endfunction

  function automatic void model_access(input bit wr, input int row, input int col,
                                       input logic [SW-1:0] wd,
                                       output logic [SW-1:0] data, output int lat);
    int slot;
    slot = col / CPS;
    lat  = (m_last_vld && m_last_row == row) ? HitLat : LAT + 2;
    if (wr) begin
      m_mem[row][slot].valid = 1'b1;
      m_mem[row][slot].data  = wd;
      m_dirty[row]           = 1'b1;
      data                   = wd;
    end else begin
      data = m_mem[row][slot].valid ? m_mem[row][slot].data : '0;
    end
    m_last_row = row;
    m_last_vld = 1'b1;
  endfunction

  function automatic void clear_logs();
    rsp_log.delete();
    rsp_cyc_log.delete();
    grant_log.delete();
    gcyc_log.delete();
  endfunction

  // Compare process: outputs against the model on every cycle.
  initial begin
    forever begin : mon
      logic [NC-1:0] em;
      @(negedge clock);
      em = '0;
      if (exp_at >= 0 && cyc == exp_at) em = NC'(1) << exp_ch;
      check("rsp_valid", rsp_valid, em);
      if (em != '0) check("rsp_data", rsp_data, exp_data);
      if (rsp_valid != '0) begin
        rsp_log.push_back(rsp_data);
        rsp_cyc_log.push_back(cyc);
      end
      if (exp_at >= 0 && cyc < exp_at) check("busy_active", busy, 1);
      if (exp_at >= 0 && cyc == exp_at) check("busy_done", busy, 0);
      if (!busy) check("dirty_rows", dirty_rows, m_dirty);
    end
  end

  // Issue the staged ops on every channel in mask and serve them to completion.
  task automatic run(input logic [NC-1:0] mask);
    logic [NC-1:0] pend;
    logic [NC-1:0] oh;
    logic [SW-1:0] d;
    int            g;
    int            t;
    int            lat;
    pend = mask;
    for (int c = 0; c < NC; c++) begin
      if (mask[c]) begin
        req_valid[c]             = 1'b1;
        req_write[c]             = op_wr[c];
        req_row[c*RW +: RW]      = RW'(op_row[c]);
        req_col[c*CW +: CW]      = CW'(op_col[c]);
        req_wdata[c*SW +: SW]    = op_wd[c];
      end
    end
    while (pend != '0) begin
      g = -1;
      for (int i = 0; i < NC; i++) begin
        if (g < 0 && pend[(m_ptr + i) % NC]) g = (m_ptr + i) % NC;
      end
      t = 0;
      do begin
        @(negedge clock);
        #1;
        t++;
      end while (req_ready == '0 && t < 40);
      oh = NC'(1) << g;
      check("grant", req_ready, oh);
      if (req_ready == '0) begin
        req_valid = '0;
        return;
      end
      model_access(op_wr[g], op_row[g], op_col[g], op_wd[g], d, lat);
      m_ptr = (g + 1) % NC;
      grant_log.push_back(g);
      gcyc_log.push_back(cyc);
      exp_ch       = g;
      exp_data     = d;
      exp_at       = cyc + lat;
      req_valid[g] = 1'b0;
      pend[g]      = 1'b0;
      do begin
        @(negedge clock);
        #1;
      end while (cyc < exp_at);
      exp_at = -1;
    end
  endtask

  task automatic stage(input int ch, input bit wr, input int row, input int col,
                       input logic [SW-1:0] wd);
    op_wr[ch]  = wr;
    op_row[ch] = row;
    op_col[ch] = col;
    op_wd[ch]  = wd;
  endtask

  task automatic op1(input int ch, input bit wr, input int row, input int col,
                     input logic [SW-1:0] wd);
    stage(ch, wr, row, col, wd);
    run(NC'(1) << ch);
  endtask

  task automatic lit_rsp(input string name, input int k, input logic [63:0] v);
    if (k < rsp_log.size()) begin
      check(name, rsp_log[k], v);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no response logged, expected %0d", name, v);
    end
  endtask

  task automatic lit_grant(input string name, input int k, input int v);
    if (k < grant_log.size()) begin
      check(name, grant_log[k], v);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no grant logged, expected %0d", name, v);
    end
  endtask

  task automatic lit_lat(input string name, input int k, input int v);
    if (k < rsp_cyc_log.size() && k < gcyc_log.size()) begin
      check(name, rsp_cyc_log[k] - gcyc_log[k], v);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: latency not observed, expected %0d", name, v);
    end
  endtask

  initial begin : main
    int t;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_busy", busy, 0);
    check("reset_dirty", dirty_rows, 0);
    reset = 1'b0;
    @(negedge clock);
    #1;

    // Pre-load row 0 from ch1 (leaves the pointer at 0), then ch0 reads.
    clear_logs();
    op1(1, 1'b1, 0, 0, SW'(1234));
    op1(1, 1'b1, 0, 32, SW'(4567));
    op1(0, 1'b0, 0, 6, '0);
    op1(0, 1'b0, 0, 6, '0);
    op1(0, 1'b0, 0, 34, '0);
    lit_rsp("preload_echo", 1, 4567);
    lit_rsp("read_0_6_a", 2, 1234);
    lit_rsp("read_0_6_b", 3, 1234);
    lit_rsp("read_0_34", 4, 4567);
    lit_lat("lat_full", 0, 4);

    // Unwritten slot reads 0 even with its neighbour valid.
    clear_logs();
    op1(0, 1'b1, 1, 0, SW'(4444));
    op1(0, 1'b0, 1, 34, '0);
    op1(0, 1'b0, 1, 0, '0);
    lit_rsp("read_unwritten", 1, 0);
    lit_rsp("read_1_0", 2, 4444);

    // Last write wins; other slot unaffected.
    clear_logs();
    op1(0, 1'b1, 4, 0, SW'(1234));
    op1(0, 1'b1, 4, 0, SW'(1232));
    lit_rsp("second_write_echo", 1, 1232);
    check("dirty_row4", dirty_rows[4], 1);
    op1(0, 1'b1, 4, 33, SW'(7777));
    op1(0, 1'b0, 4, 33, '0);
    op1(0, 1'b0, 4, 0, '0);
    lit_rsp("read_4_33", 3, 7777);
    lit_rsp("read_4_0", 4, 1232);

    // Simultaneous reads with pointer at 0, then with pointer at 1.
    op1(1, 1'b0, 3, 0, '0);
    clear_logs();
    stage(0, 1'b0, 0, 6, '0);
    stage(1, 1'b0, 0, 34, '0);
    run(2'b11);
    lit_grant("rr_first_ptr0", 0, 0);
    lit_grant("rr_second_ptr0", 1, 1);
    lit_rsp("rr_data_ch0", 0, 1234);
    lit_rsp("rr_data_ch1", 1, 4567);
    op1(0, 1'b0, 2, 0, '0);
    clear_logs();
    stage(0, 1'b0, 4, 33, '0);
    stage(1, 1'b0, 1, 0, '0);
    run(2'b11);
    lit_grant("rr_first_ptr1", 0, 1);
    lit_grant("rr_second_ptr1", 1, 0);
    lit_rsp("rr_data_ch1_b", 0, 4444);
    lit_rsp("rr_data_ch0_b", 1, 7777);

    // Two consecutive reads of row 2 (after a different row).
    clear_logs();
    op1(0, 1'b0, 2, 0, '0);
    op1(0, 1'b0, 2, 40, '0);
    lit_lat("row2_first_lat", 0, 4);
    lit_lat("row2_second_lat", 1, HitLat);
    check("dirty_row2_clean", dirty_rows[2], 0);

    // Reset while a write is in RD: dropped with no response.
    req_valid[0]         = 1'b1;
    req_write[0]         = 1'b1;
    req_row[0 +: RW]     = RW'(5);
    req_col[0 +: CW]     = '0;
    req_wdata[0 +: SW]   = SW'(9999);
    t = 0;
    do begin
      @(negedge clock);
      #1;
      t++;
    end while (req_ready == '0 && t < 40);
    check("rst_grant", req_ready, 2'b01);
    req_valid = '0;
    model_reset();
    exp_at = -1;
    reset  = 1'b1;
    @(negedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    #1;
    clear_logs();
    op1(0, 1'b0, 5, 0, '0);
    op1(0, 1'b0, 0, 0, '0);
    lit_rsp("after_reset_row5", 0, 0);
    lit_rsp("after_reset_row0", 1, 0);
    check("after_reset_rsp_count", rsp_log.size(), 2);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
